// File: rtl/left_shift_by_one_pkg.sv
// -----------------------------------------------------------------------------
// left_shift_by_one_pkg
// Shared constants and helpers for the registered shift-left-by-one block.
//   DEFAULT_WIDTH : default datapath width (64 bits)
//   MAX_WIDTH     : widest operand the zero-detect helper accepts
//   is_all_zero() : zero-compare helper used by the shift core
// -----------------------------------------------------------------------------
package left_shift_by_one_pkg;

    localparam int DEFAULT_WIDTH = 64;

    // Upper bound for the zero helper; narrower operands are zero-extended
    // before the call, which leaves the result unchanged.
    localparam int MAX_WIDTH = 1024;

    function automatic logic is_all_zero(input logic [MAX_WIDTH-1:0] value);
        return (value == {MAX_WIDTH{1'b0}});
    endfunction

endpackage : left_shift_by_one_pkg

// File: rtl/left_shift_by_one_core.sv
// -----------------------------------------------------------------------------
// left_shift_by_one_core
// Purely combinational shift-left-by-one with carry-out and zero detect.
// Ports:
//   in       [WIDTH-1:0] operand
//   fill_bit             value inserted at bit 0
//   shifted  [WIDTH-1:0] {in[WIDTH-2:0], fill_bit}
//   co                   bit shifted out (in[WIDTH-1])
//   z                    1 when shifted is all zeros
// WIDTH must be at least 2 and at most MAX_WIDTH.
// -----------------------------------------------------------------------------
module left_shift_by_one_core
    import left_shift_by_one_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic             fill_bit,
    output logic [WIDTH-1:0] shifted,
    output logic             co,
    output logic             z
);

    logic [MAX_WIDTH-1:0] shifted_ext;

    // Logical shift: the MSB leaves through co and is never rotated into bit 0.
    assign shifted     = {in[WIDTH-2:0], fill_bit};
    assign co          = in[WIDTH-1];
    assign shifted_ext = MAX_WIDTH'(shifted);
    assign z           = is_all_zero(shifted_ext);

endmodule : left_shift_by_one_core

// File: rtl/left_shift_by_one.sv
// -----------------------------------------------------------------------------
// left_shift_by_one
// Registered logical left shift by one bit, latency 1, one operand per cycle.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies in / fill_bit this cycle
//   in         [WIDTH-1:0] operand
//   fill_bit   value inserted at bit 0 (tie 0 for a plain shift)
//   out_valid  out / carry_out / zero hold a result produced last cycle
//   out        [WIDTH-1:0] registered {in[WIDTH-2:0], fill_bit}
//   carry_out  registered in[WIDTH-1]
//   zero       registered "out is all zeros"
// -----------------------------------------------------------------------------
module left_shift_by_one
    import left_shift_by_one_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             fill_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             zero
);

    logic [WIDTH-1:0] shifted;
    logic             co;
    logic             z;

    left_shift_by_one_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in       (in),
        .fill_bit (fill_bit),
        .shifted  (shifted),
        .co       (co),
        .z        (z)
    );

    // NOTE: every output register is cleared by reset; zero resets to 0 because
    // no valid result exists while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the
            // same pre-edge values.
            out_valid <= in_valid;
            // Data registers only load on a valid operand, so garbage on in
            // while in_valid is low never reaches the outputs.
            if (in_valid) begin
                out       <= shifted;
                carry_out <= co;
                zero      <= z;
            end
        end
    end

endmodule : left_shift_by_one

// File: tb/tb_left_shift_by_one.sv
// -----------------------------------------------------------------------------
// tb_left_shift_by_one
// Self-checking bench: directed cases with literal expectations, then random
// traffic, all compared every cycle against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_left_shift_by_one;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         fill_bit;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         carry_out;
    logic         zero;

    // Reference model state: what the outputs must show after the last edge.
    logic         m_valid;
    logic [W-1:0] m_out;
    logic         m_co;
    logic         m_zero;

    int  n_checks = 0;
    int  n_fails  = 0;
    bit  cmp_en   = 1'b0;

    left_shift_by_one #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in_data),
        .fill_bit  (fill_bit),
        .out_valid (out_valid),
        .out       (out_data),
        .carry_out (carry_out),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_out   = '0;
        m_co    = 1'b0;
        m_zero  = 1'b0;
    endtask

    // Apply one cycle of input, advance past the edge, update the model.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic f);
        logic [W:0] doubled;
        in_valid = v;
        in_data  = d;
        fill_bit = f;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_valid = v;
            if (v) begin
                // Multiply by two plus fill; the extra top bit is the carry.
                doubled = {1'b0, d} * 2 + {{W{1'b0}}, f};
                m_out   = doubled[W-1:0];
                m_co    = doubled[W];
                m_zero  = (m_out == 0);
            end
        end
        #1;
    endtask

    task automatic check_lit(input string name, input logic v, input logic [W-1:0] o,
                             input logic c, input logic z);
        check({name, ".valid"}, W'(out_valid), W'(v));
        check({name, ".out"},   out_data,      o);
        check({name, ".carry"}, W'(carry_out), W'(c));
        check({name, ".zero"},  W'(zero),      W'(z));
    endtask

    // Every-cycle comparison of the DUT against the model, mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc.valid", W'(out_valid), W'(m_valid));
            check("cyc.out",   out_data,      m_out);
            check("cyc.carry", W'(carry_out), W'(m_co));
            check("cyc.zero",  W'(zero),      W'(m_zero));
        end
    end

    initial begin
        logic [W-1:0] r;
        in_valid = 1'b0;
        in_data  = '0;
        fill_bit = 1'b0;
        model_clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: inputs toggle, outputs stay cleared.
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        drive(1'b0, 64'h8000_0000_0000_0000, 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_lit("reset_hold", 1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 64'h1234, 1'b0);
        drive(1'b0, 64'h5678, 1'b1);
        check_lit("post_reset", 1'b0, 64'h0, 1'b0, 1'b0);

        // Walking values.
        drive(1'b1, 64'h1, 1'b0); check_lit("walk1", 1'b1, 64'h2,  1'b0, 1'b0);
        drive(1'b1, 64'h2, 1'b0); check_lit("walk2", 1'b1, 64'h4,  1'b0, 1'b0);
        drive(1'b1, 64'h4, 1'b0); check_lit("walk4", 1'b1, 64'h8,  1'b0, 1'b0);
        drive(1'b1, 64'h8, 1'b0); check_lit("walk8", 1'b1, 64'h10, 1'b0, 1'b0);

        // MSB shift-out and all ones.
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0);
        check_lit("msb", 1'b1, 64'h0, 1'b1, 1'b1);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check_lit("ones", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        // Hold on invalid, including undriven operand bits.
        drive(1'b1, 64'h5, 1'b0);   check_lit("hold_a", 1'b1, 64'hA, 1'b0, 1'b0);
        drive(1'b0, 64'h123, 1'b1); check_lit("hold_b", 1'b0, 64'hA, 1'b0, 1'b0);
        drive(1'b0, 'x, 1'bx);      check_lit("hold_x", 1'b0, 64'hA, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        drive(1'b1, 64'h8, 1'b0);   check_lit("pre_arst", 1'b1, 64'h10, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_lit("arst", 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Zero input with both fill values.
        drive(1'b1, 64'h0, 1'b0); check_lit("zero_f0", 1'b1, 64'h0, 1'b0, 1'b1);
        drive(1'b1, 64'h0, 1'b1); check_lit("zero_f1", 1'b1, 64'h1, 1'b0, 1'b0);

        // Random traffic with occasional boundary operands.
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: r = '0;
                1: r = 64'h8000_0000_0000_0000;
                2: r = '1;
                default: ;
            endcase
            drive(($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 1)));
        end

        drive(1'b0, '0, 1'b0);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_left_shift_by_one

// File: doc/left_shift_by_one.md
Name: left_shift_by_one

Overview:
- Registered logical left shift by one bit position for a WIDTH-bit datapath (default 64).
- Used as a datapath building block, e.g. for multiply-by-2 and address/offset scaling in the execute stage.
- A combinational shift core feeds a single output register stage with a valid flag, carry-out and zero flag.
- Latency is 1 clock.

Parameters:
- WIDTH, 64, datapath width in bits; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in/fill_bit this cycle.
- in  input  WIDTH  operand to shift.
- fill_bit  input  1  value inserted at bit 0; tie to 0 for a plain logical shift.
- out_valid  output  1  out/carry_out/zero hold a valid result.
- out  output  WIDTH  registered result: {in[WIDTH-2:0], fill_bit}.
- carry_out  output  1  registered in[WIDTH-1], the bit shifted out.
- zero  output  1  registered flag, 1 when the registered out is all zeros.

Behaviour:
- Reset:
  - rst_n low asynchronously clears out_valid, out, carry_out and zero to 0, independent of clk.
  - zero resets to 0, not 1, because there is no valid result during reset.
  - Deassertion takes effect at the next rising clk edge. Reset mid-stream discards any in-flight result.
- Core function, purely combinational:
  - shifted = {in[WIDTH-2:0], fill_bit}
  - co = in[WIDTH-1]
  - z = (shifted == 0)
- Register stage, on rising clk edge with rst_n high:
  - out_valid <= in_valid.
  - If in_valid = 1: out <= shifted, carry_out <= co, zero <= z.
  - If in_valid = 0: out, carry_out and zero hold their previous values. Only out_valid drops.
- Latency and throughput:
  - Operand applied in cycle N appears at the outputs after the edge ending cycle N.
  - Accepts one operand per cycle. No backpressure and no ready signal.
- Width and arithmetic rules:
  - Logical shift, no sign extension.
  - Overflow is reported only through carry_out. No wrap-around, so bit WIDTH-1 is never rotated into bit 0.
- Boundary conditions:
  - in = 0 with fill_bit = 0 gives out = 0, zero = 1, carry_out = 0.
  - in = only the MSB set with fill_bit = 0 gives out = 0, zero = 1, carry_out = 1.
  - All ones with fill_bit = 1 gives out = all ones, carry_out = 1, zero = 0.
  - X/Z on in while in_valid = 0 must not affect outputs.
- No internal state beyond the output registers; no FSM.

Decomposition:
- Shared package holds:
  - default WIDTH constant (64)
  - a zero-constant helper for the zero compare
- Natural sub-module: left_shift_core, the combinational shift, carry and zero-detect logic, parameterized on WIDTH.
- Top level left_shift_by_one instantiates left_shift_core plus the async-reset register stage.

Test Plan:
1. Reset: hold rst_n = 0, toggle in and in_valid → out = 0, out_valid = 0, carry_out = 0, zero = 0. Deassert rst_n → outputs stay 0 until the first valid operand.
2. Walking values, fill_bit = 0, in_valid = 1, in = 1, 2, 4, 8 on consecutive cycles → out = 2, 4, 8, 16 one cycle later each; carry_out = 0, zero = 0, out_valid = 1.
3. MSB shift-out: in = 0x8000_0000_0000_0000 → out = 0, carry_out = 1, zero = 1. Then in = 0xFFFF_FFFF_FFFF_FFFF with fill_bit = 1 → out = 0xFFFF_FFFF_FFFF_FFFF, carry_out = 1.
4. Hold on invalid: in = 0x5 valid → out = 0xA. Next cycle in = 0x123 with in_valid = 0 → out_valid = 0, out stays 0xA.
5. Async reset mid-stream: with out = 0x10 valid, pull rst_n low between clock edges → all outputs become 0 immediately, before the next edge.
6. Zero input: in = 0, fill_bit = 0 → out = 0, zero = 1, carry_out = 0. Same input with fill_bit = 1 → out = 1, zero = 0.
